// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the AXI read-path arbiter.
package axi_arb_pkg;

  localparam int unsigned NUM_MASTERS     = 4;
  localparam int unsigned ID_W            = $clog2(NUM_MASTERS);
  localparam int unsigned MAX_OUTSTANDING = 4;
  localparam int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned MAX_BURSTS      = 8;
  localparam int unsigned QUOTA_W         = $clog2(MAX_BURSTS + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

  function automatic logic [NUM_MASTERS-1:0] onehot_from_id(input logic [ID_W-1:0] id);
    return NUM_MASTERS'(1) << id;
  endfunction

endpackage

// File: rtl/axi_rr_picker.sv
// Combinational round-robin picker: first requester after last_id, wrapping.
module axi_rr_picker #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_id,
  output logic [IW-1:0] pick_id,
  output logic          pick_valid
);

  logic [IW-1:0] w_idx;

  // Offset 1 is checked first so last_id itself has lowest priority.
  always_comb begin
    pick_id    = '0;
    pick_valid = 1'b0;
    w_idx      = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_idx = IW'((32'(last_id) + k) % N);
      if (!pick_valid && req[w_idx]) begin
        pick_id    = w_idx;
        pick_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Round-robin grant holder for the shared AXI read path with
// outstanding-burst tracking and per-tenure AR quota.
module axi_rd_arbiter
  import axi_arb_pkg::*;
(
  input  logic                   ACLK,
  input  logic                   ARESETn,
  input  logic [NUM_MASTERS-1:0] m_arvalid,
  input  logic                   bus_arready,
  input  logic                   bus_rvalid,
  input  logic                   bus_rready,
  input  logic                   bus_rlast,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [ID_W-1:0]        grant_id,
  output logic                   grant_valid,
  output logic                   ar_allow,
  output logic [CNT_W-1:0]       outstanding,
  output logic                   err_underflow
);

  arb_state_e             r_state,    w_state_nxt;
  logic [NUM_MASTERS-1:0] r_grant,    w_grant_nxt;
  logic [ID_W-1:0]        r_grant_id, w_grant_id_nxt;
  logic [ID_W-1:0]        r_last_id,  w_last_id_nxt;
  logic [CNT_W-1:0]       r_cnt,      w_cnt_nxt;
  logic [QUOTA_W-1:0]     r_quota,    w_quota_nxt;
  logic                   r_err,      w_err_nxt;

  logic            w_ar_hs;
  logic            w_r_done;
  logic            w_underflow;
  logic [ID_W-1:0] w_pick_id;
  logic            w_pick_valid;

  axi_rr_picker #(.N(NUM_MASTERS), .IW(ID_W)) u_picker (
    .req        (m_arvalid),
    .last_id    (r_last_id),
    .pick_id    (w_pick_id),
    .pick_valid (w_pick_valid)
  );

  assign ar_allow    = (r_state == ST_GRANT) && (r_cnt < CNT_W'(MAX_OUTSTANDING));
  assign w_ar_hs     = ar_allow & m_arvalid[r_grant_id] & bus_arready;
  assign w_r_done    = bus_rvalid & bus_rready & bus_rlast;
  assign w_underflow = w_r_done && (r_cnt == '0);

  // A completion with nothing outstanding is flagged rather than wrapping the count.
  always_comb begin
    if (w_underflow) w_cnt_nxt = r_cnt + CNT_W'(w_ar_hs);
    else             w_cnt_nxt = r_cnt + CNT_W'(w_ar_hs) - CNT_W'(w_r_done);
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_grant_id_nxt = r_grant_id;
    w_last_id_nxt  = r_last_id;
    w_quota_nxt    = r_quota;
    w_err_nxt      = r_err | w_underflow;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt    = ST_GRANT;
          w_grant_nxt    = onehot_from_id(w_pick_id);
          w_grant_id_nxt = w_pick_id;
          w_last_id_nxt  = w_pick_id;
          w_quota_nxt    = '0;
        end
      end
      ST_GRANT: begin
        if (w_ar_hs) w_quota_nxt = r_quota + QUOTA_W'(1);
        if (!m_arvalid[r_grant_id] && (w_cnt_nxt == '0)) begin
          w_state_nxt    = ST_IDLE;
          w_grant_nxt    = '0;
          w_grant_id_nxt = '0;
        end else if (!m_arvalid[r_grant_id]) begin
          w_state_nxt = ST_DRAIN;
        end else if (w_ar_hs && (r_quota + QUOTA_W'(1) == QUOTA_W'(MAX_BURSTS))) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_cnt_nxt == '0) begin
          w_state_nxt    = ST_IDLE;
          w_grant_nxt    = '0;
          w_grant_id_nxt = '0;
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_grant_nxt    = '0;
        w_grant_id_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_grant_id <= '0;
      r_last_id  <= ID_W'(NUM_MASTERS - 1);
      r_cnt      <= '0;
      r_quota    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_last_id  <= w_last_id_nxt;
      r_cnt      <= w_cnt_nxt;
      r_quota    <= w_quota_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign grant         = r_grant;
  assign grant_id      = r_grant_id;
  assign grant_valid   = (r_state != ST_IDLE);
  assign outstanding   = r_cnt;
  assign err_underflow = r_err;

endmodule
